// File: rtl/branch_pc_unit.sv
// PC sequencer and ALU flag register with start/run/halt control.
// Optional BRANCH_LUT_EN: taken branches jump to an absolute target from a 16-entry LUT.
module branch_pc_unit #(
   parameter int PC_W = 10
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            Start,
   input  logic [PC_W-1:0] StartAddr,
   input  logic            Halt,
   input  logic            FlagWr,
   input  logic            ZeroIn,
   input  logic            LTIn,
   input  logic [1:0]      BrOp,
   input  logic [7:0]      Offset,
   input  logic            LutWr,
   input  logic [3:0]      LutAddr,
   input  logic [PC_W-1:0] LutData,
   output logic [PC_W-1:0] PC,
   output logic            ZeroFlag,
   output logic            LTFlag,
   output logic            Taken,
   output logic            Running,
   output logic            Done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t          state;
   logic            take;
   logic [PC_W-1:0] target;

   // Decision uses the stored flags, so a coincident FlagWr cannot affect it.
   always_comb begin
      take = 1'b0;
      unique case (BrOp)
         2'b01:   take = ZeroFlag;
         2'b10:   take = LTFlag;
         2'b11:   take = 1'b1;
         default: take = 1'b0;
      endcase
   end

`ifdef BRANCH_LUT_EN
   logic [PC_W-1:0] lut [16];
   logic            unused_off;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 16; i++) lut[i] <= '0;
      end else if (LutWr) begin
         lut[LutAddr] <= LutData;
      end
   end

   assign target     = lut[Offset[3:0]];
   assign unused_off = ^Offset[7:4];
`else
   logic unused_lut;

   assign target     = PC + PC_W'($signed(Offset));
   assign unused_lut = ^{LutWr, LutAddr, LutData};
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         PC       <= '0;
         ZeroFlag <= 1'b0;
         LTFlag   <= 1'b0;
         Taken    <= 1'b0;
         Running  <= 1'b0;
         Done     <= 1'b0;
      end else begin
         Taken <= 1'b0;
         if (FlagWr) begin
            ZeroFlag <= ZeroIn;
            LTFlag   <= LTIn;
         end
         unique case (state)
            IDLE, HALT: begin
               if (Start) begin
                  state   <= RUN;
                  PC      <= StartAddr;
                  Running <= 1'b1;
                  Done    <= 1'b0;
               end
            end
            RUN: begin
               if (Halt) begin
                  state   <= HALT;
                  Running <= 1'b0;
                  Done    <= 1'b1;
               end else begin
                  PC    <= take ? target : PC + PC_W'(1);
                  Taken <= take;
               end
            end
            default: begin
               state   <= IDLE;
               Running <= 1'b0;
               Done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and flag-register stage directly downstream of the 8-bit ALU.
- Captures the ALU's `Zero`/`LT` results into architectural flag registers.
- Evaluates conditional and unconditional branches against those flags.
- Sequences the PC through a start/run/halt lifecycle.
- Its `PC` output addresses instruction memory; its flag outputs are architectural state visible to the controller.

## Interface
Parameters:
- `PC_W`, 10, program-counter width; instruction memory depth is 2^PC_W.

Ports:
- `Clk`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  pulse; starts or restarts execution at `StartAddr`.
- `StartAddr`  in  PC_W  initial PC.
- `Halt`  in  1  stop execution; sampled in RUN only.
- `FlagWr`  in  1  capture `ZeroIn`/`LTIn` at this edge.
- `ZeroIn`  in  1  ALU `Zero` result.
- `LTIn`  in  1  ALU `LT` result.
- `BrOp`  in  2  00 none, 01 branch-if-zero, 10 branch-if-LT, 11 unconditional.
- `Offset`  in  8  signed two's-complement relative offset (LUT index when LUT enabled).
- `LutWr`  in  1  write enable for the branch-target LUT.
- `LutAddr`  in  4  LUT write index.
- `LutData`  in  PC_W  LUT write data.
- `PC`  out  PC_W  current program counter.
- `ZeroFlag`  out  1  stored zero flag.
- `LTFlag`  out  1  stored less-than flag.
- `Taken`  out  1  registered; high for one cycle after a taken branch.
- `Running`  out  1  high in RUN.
- `Done`  out  1  high in HALT.

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - HALT
- Transitions:
  - IDLE --Start--> RUN; PC <= StartAddr.
  - RUN --Halt--> HALT; PC holds.
  - HALT --Start--> RUN; PC <= StartAddr.
  - Start in RUN is ignored.
  - Halt in IDLE or HALT is ignored.
- In RUN without Halt, each edge loads PC with:
  - PC + sext(Offset), when the branch is taken;
  - PC + 1, otherwise.
- Branch is taken when:
  - BrOp=11, or
  - BrOp=01 and ZeroFlag=1, or
  - BrOp=10 and LTFlag=1.
- Branches always evaluate the stored flags, i.e. the values before this edge. When FlagWr and BrOp coincide, the branch uses the old flags and the flags update at the same edge.
- Flags update on FlagWr in any state, including IDLE and HALT.
- Arithmetic is modulo 2^PC_W:
  - Increment wraps from 2^PC_W-1 to 0.
  - Negative offsets wrap below 0.
  - Offset 0 taken holds PC (self-loop; legal).
- Halt and a taken branch in the same cycle: Halt wins, PC holds, Taken=0.
- Taken is asserted only for branches taken in RUN. BrOp is ignored outside RUN.

## Timing
- Reset (asynchronous, immediate on Reset_n low) forces:
  - PC=0, ZeroFlag=0, LTFlag=0, Taken=0, Running=0, Done=0;
  - state IDLE;
  - all LUT entries = 0.
- Reset asserted mid-RUN aborts immediately. Release returns to IDLE and requires a new Start.
- All outputs are registered and change only on a rising Clk or on reset.
- Latencies:
  - Start edge: PC=StartAddr and Running=1 visible the next cycle.
  - Branch: the decision is combinational from BrOp/Offset and the stored flags; the target appears on PC after one edge. Taken is high for exactly that following cycle.
  - Flags: FlagWr is visible on ZeroFlag/LTFlag after one edge.

## Configuration
- `BRANCH_LUT_EN` defined:
  - Taken-branch target is the absolute value LUT[Offset[3:0]]; Offset[7:4] is ignored.
  - The LUT is 16 x PC_W and written via LutWr/LutAddr/LutData in any state.
  - A write and a read of the same entry in the same cycle: the branch uses the old contents.
- `BRANCH_LUT_EN` undefined:
  - Relative addressing PC + sext(Offset).
  - LutWr, LutAddr and LutData are ignored and no LUT storage is built.

## Test plan
- Reset, then Start with StartAddr=0x010 and no branches for 4 cycles -> PC reads 0x010, 0x011, 0x012, 0x013; Running=1, Taken=0.
- FlagWr with ZeroIn=1 while BrOp=01 and Offset=+5 at PC=0x020:
  - that edge: not taken (old ZeroFlag=0), PC=0x021;
  - next cycle, BrOp=01 again: PC=0x026, Taken=1 for one cycle.
- PC_W=10, PC=0x3FF, no branch -> PC=0x000. Then BrOp=11 with Offset=0xFE -> PC=0x3FE.
- In RUN, Halt together with BrOp=11 and Offset=+3 at PC=0x040:
  - PC stays 0x040, Done=1, Running=0, Taken=0;
  - a later Start with StartAddr=0x100 gives PC=0x100 and Running=1.
- Reset_n pulsed low mid-RUN at PC=0x055 -> outputs clear immediately; after release the state is IDLE, BrOp has no effect until Start.
- With BRANCH_LUT_EN: write LUT[3]=0x2A0, then BrOp=11 with Offset=0xF3 -> PC=0x2A0. Without the macro, the same stimulus gives PC = PC-13 mod 1024.
